sdram_read: RTL and testbench



---
 rtl/sdram_read_pkg.sv | 38 +++
 rtl/sdram_read_if.sv | 32 +++
 rtl/sdram_read.sv | 121 ++++++++++++
 tb/tb_sdram_read.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_pkg.sv
// Shared types and SDRAM command encodings for the read-path controller.
// Commands are {CS_n, RAS_n, CAS_n, WE_n}, matching the other SDRAM blocks.
package sdram_read_pkg;

    localparam logic [3:0]  CMD_NOP    = 4'b0111;
    localparam logic [3:0]  CMD_ACTIVE = 4'b0011;
    localparam logic [3:0]  CMD_READ   = 4'b0101;
    localparam logic [3:0]  CMD_BST    = 4'b0110;
    localparam logic [3:0]  CMD_PRE    = 4'b0010;

    localparam logic [1:0]  BA_IDLE    = 2'b11;
    localparam logic [12:0] ADDR_IDLE  = 13'h1FFF;
    localparam logic [12:0] ADDR_PRE   = 13'h0400;

    typedef enum logic [3:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_TRCD,
        RD_READ,
        RD_DATA,
        RD_CL,
        RD_PRE,
        RD_TRP,
        RD_END
    } rd_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_cmd_t;

    // A zero-length request is served as a single word.
    function automatic logic [9:0] burst_last(input logic [9:0] len);
        return (len == 10'd0) ? 10'd0 : len - 10'd1;
    endfunction

endpackage

// File: rtl/sdram_read_if.sv
// Arbiter-facing bundle of the read-path controller: request, SDRAM command pins and read data.
// The request is a level qualified by init_end_i and sampled only while the controller is idle.
interface sdram_read_if;
    import sdram_read_pkg::*;

    logic        init_end_i;
    logic        rd_en_i;
    logic [23:0] rd_addr_i;
    logic [9:0]  rd_burst_lenth_i;
    logic [15:0] rd_sdram_data_i;
    logic        rd_ack_o;
    logic        rd_end_o;
    logic [3:0]  read_cmd_o;
    logic [1:0]  read_ba_o;
    logic [12:0] read_addr_o;
    logic [15:0] rd_data_o;
    logic        rd_data_valid_o;
    rd_state_e   rd_state;

    modport slave (
        input  init_end_i, rd_en_i, rd_addr_i, rd_burst_lenth_i, rd_sdram_data_i,
        output rd_ack_o, rd_end_o, read_cmd_o, read_ba_o, read_addr_o,
        output rd_data_o, rd_data_valid_o, rd_state
    );

    modport master (
        output init_end_i, rd_en_i, rd_addr_i, rd_burst_lenth_i, rd_sdram_data_i,
        input  rd_ack_o, rd_end_o, read_cmd_o, read_ba_o, read_addr_o,
        input  rd_data_o, rd_data_valid_o, rd_state
    );

endinterface

// File: rtl/sdram_read.sv
// SDR SDRAM read path: ACTIVE, READ, BURST TERMINATE, PRECHARGE sequencing and
// CAS-latency aligned capture of a full-page burst.
module sdram_read
    import sdram_read_pkg::*;
#(
    parameter int CAS_LATENCY      = 3,
    parameter int TRCD_CLK_CNT_MAX = 2,
    parameter int TRP_CLK_CNT_MAX  = 2
) (
    input logic         sys_clk_i,
    input logic         rst_i,
    sdram_read_if.slave bus
);

    localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK_CNT_MAX - 1);
    localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK_CNT_MAX - 1);
    localparam logic [9:0] CL_LAST   = 10'(CAS_LATENCY);

    rd_state_e              state_q, state_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [23:0]            addr_q, addr_d;
    logic [9:0]             last_q, last_d;
    sdram_cmd_t             cmd_q, cmd_d;
    logic [CAS_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [15:0]            data_q, data_d;
    logic                   valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 10'd1;
        addr_d  = addr_q;
        last_d  = last_q;
        case (state_q)
            RD_IDLE: begin
                cnt_d = '0;
                if (bus.rd_en_i && bus.init_end_i) begin
                    state_d = RD_ACTIVE;
                    addr_d  = bus.rd_addr_i;
                    last_d  = burst_last(bus.rd_burst_lenth_i);
                end
            end
            RD_ACTIVE: state_d = RD_TRCD;
            RD_TRCD:   if (cnt_q == TRCD_LAST) state_d = RD_READ;
            RD_READ:   state_d = RD_DATA;
            RD_DATA:   if (cnt_q == last_q) state_d = RD_CL;
            RD_CL:     if (cnt_q == CL_LAST) state_d = RD_PRE;
            RD_PRE:    state_d = RD_TRP;
            RD_TRP:    if (cnt_q == TRP_LAST) state_d = RD_END;
            RD_END:    state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Commands are registered from the current state, so they lag state entry by one clock.
    always_comb begin
        cmd_d.cmd  = CMD_NOP;
        cmd_d.ba   = BA_IDLE;
        cmd_d.addr = ADDR_IDLE;
        case (state_q)
            RD_ACTIVE: begin
                cmd_d.cmd  = CMD_ACTIVE;
                cmd_d.ba   = addr_q[23:22];
                cmd_d.addr = addr_q[21:9];
            end
            RD_READ: begin
                cmd_d.cmd  = CMD_READ;
                cmd_d.ba   = addr_q[23:22];
                cmd_d.addr = {4'b0000, addr_q[8:0]};
            end
            RD_DATA: if (cnt_q == last_q) cmd_d.cmd = CMD_BST;
            RD_PRE: begin
                cmd_d.cmd  = CMD_PRE;
                cmd_d.ba   = addr_q[23:22];
                cmd_d.addr = ADDR_PRE;
            end
            default: ;
        endcase
    end

    // RD_DATA spans the N clocks after READ appears on the pins; delaying it by CL marks the sampled beats.
    always_comb begin
        vld_sr_d = {vld_sr_q[CAS_LATENCY-2:0], (state_q == RD_DATA)};
        valid_d  = vld_sr_q[CAS_LATENCY-1];
        data_d   = vld_sr_q[CAS_LATENCY-1] ? bus.rd_sdram_data_i : data_q;
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            last_q     <= '0;
            cmd_q.cmd  <= CMD_NOP;
            cmd_q.ba   <= BA_IDLE;
            cmd_q.addr <= ADDR_IDLE;
            vld_sr_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            cmd_q    <= cmd_d;
            vld_sr_q <= vld_sr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.read_cmd_o      = cmd_q.cmd;
    assign bus.read_ba_o       = cmd_q.ba;
    assign bus.read_addr_o     = cmd_q.addr;
    assign bus.rd_data_o       = data_q;
    assign bus.rd_data_valid_o = valid_q;
    assign bus.rd_ack_o        = (state_q == RD_DATA);
    assign bus.rd_end_o        = (state_q == RD_END);
    assign bus.rd_state        = state_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: a CL=3 and a CL=2 instance share one request stream and are
// compared every clock against a timeline model measured in edges from request acceptance.
module tb_sdram_read;
    import sdram_read_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd_en    = 1'b0;
    logic        init_end = 1'b0;
    logic [23:0] addr_in  = '0;
    logic [9:0]  len_in   = '0;
    logic [15:0] req_base = '0;

    sdram_read_if bus0 ();
    sdram_read_if bus1 ();

    assign bus0.rd_en_i = rd_en;  assign bus0.init_end_i = init_end;
    assign bus0.rd_addr_i = addr_in;  assign bus0.rd_burst_lenth_i = len_in;
    assign bus1.rd_en_i = rd_en;  assign bus1.init_end_i = init_end;
    assign bus1.rd_addr_i = addr_in;  assign bus1.rd_burst_lenth_i = len_in;

    sdram_read #(.CAS_LATENCY(3), .TRCD_CLK_CNT_MAX(2), .TRP_CLK_CNT_MAX(2)) u_dut_cl3 (
        .sys_clk_i(clk), .rst_i(rst), .bus(bus0));
    sdram_read #(.CAS_LATENCY(2), .TRCD_CLK_CNT_MAX(2), .TRP_CLK_CNT_MAX(2)) u_dut_cl2 (
        .sys_clk_i(clk), .rst_i(rst), .bus(bus1));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model + scoreboard ----------------
    int          g = 0;
    int          passed = 0;
    int          total = 0;
    bit          busy [2];
    int          acc [2];
    int          n [2];
    logic [23:0] maddr [2];
    logic [15:0] bases [2];
    logic [15:0] last_data [2];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    function automatic int cl_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic void push_exp(input int i, input logic [15:0] v);
        if (i == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    endfunction

    function automatic logic [15:0] pop_exp(input int i);
        if (i == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic int size_exp(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void flush_exp(input int i);
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d edge %0d observed=%0h expected=%0h", tag, i, g, obs, exp);
    endtask

    // Applies what the edge just sampled: reset, acceptance of a request, burst retirement.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy[i] = 1'b0;
                last_data[i] = '0;
                flush_exp(i);
            end else if (!busy[i] && rd_en && init_end) begin
                busy[i]  = 1'b1;
                acc[i]   = g;
                n[i]     = (len_in == 10'd0) ? 1 : int'(len_in);
                maddr[i] = addr_in;
                bases[i] = req_base;
                for (int k = 0; k < n[i]; k++) push_exp(i, req_base + 16'(k));
            end else if (busy[i] && (g - acc[i]) >= 9 + n[i] + cl_of(i)) begin
                busy[i] = 1'b0;
                chk("beats_left", i, size_exp(i), 0);
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [3:0] cmd, input logic [1:0] ba,
                             input logic [12:0] ad, input logic vld, input logic [15:0] dat,
                             input logic ack, input logic en);
        logic [3:0]  e_cmd = CMD_NOP;
        logic [1:0]  e_ba  = 2'b11;
        logic [12:0] e_ad  = 13'h1FFF;
        logic        e_vld = 1'b0;
        logic        e_ack = 1'b0;
        logic        e_end = 1'b0;
        if (busy[i]) begin
            int e = g - acc[i];
            int c = cl_of(i);
            int nn = n[i];
            if (e == 1) begin
                e_cmd = CMD_ACTIVE; e_ba = maddr[i][23:22]; e_ad = maddr[i][21:9];
            end else if (e == 4) begin
                e_cmd = CMD_READ; e_ba = maddr[i][23:22]; e_ad = {4'b0000, maddr[i][8:0]};
            end else if (e == 4 + nn) begin
                e_cmd = CMD_BST;
            end else if (e == 6 + nn + c) begin
                e_cmd = CMD_PRE; e_ba = maddr[i][23:22]; e_ad = 13'h0400;
            end
            e_vld = (e >= 5 + c) && (e <= 4 + c + nn);
            e_ack = (e >= 4) && (e <= 3 + nn);
            e_end = (e == 8 + nn + c);
        end
        if (e_vld && size_exp(i) > 0) last_data[i] = pop_exp(i);
        chk("read_cmd", i, cmd, e_cmd);
        if (e_cmd != CMD_BST) begin
            chk("read_ba", i, ba, e_ba);
            chk("read_addr", i, ad, e_ad);
        end
        chk("rd_valid", i, vld, e_vld);
        chk("rd_data", i, dat, last_data[i]);
        chk("rd_ack", i, ack, e_ack);
        chk("rd_end", i, en, e_end);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_dq();
        for (int i = 0; i < 2; i++) begin
            logic [15:0] v = 16'($urandom);
            int k = g - acc[i] - 4 - cl_of(i);
            if (busy[i] && k >= 0 && k < n[i]) v = bases[i] + 16'(k);
            if (i == 0) bus0.rd_sdram_data_i = v; else bus1.rd_sdram_data_i = v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        g++;
        model_step();
        #1;
        check_dut(0, bus0.read_cmd_o, bus0.read_ba_o, bus0.read_addr_o, bus0.rd_data_valid_o,
                  bus0.rd_data_o, bus0.rd_ack_o, bus0.rd_end_o);
        check_dut(1, bus1.read_cmd_o, bus1.read_ba_o, bus1.read_addr_o, bus1.rd_data_valid_o,
                  bus1.rd_data_o, bus1.rd_ack_o, bus1.rd_end_o);
        drive_dq();
    endtask

    task automatic request(input logic [23:0] a, input logic [9:0] len, input logic [15:0] base);
        rd_en = 1'b1; addr_in = a; len_in = len; req_base = base;
        tick();
        rd_en = 1'b0; addr_in = 24'($urandom); len_in = 10'($urandom); req_base = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy[0] || busy[1]) && t < budget) begin
            tick();
            t++;
        end
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus0.rd_sdram_data_i = '0;
        bus1.rd_sdram_data_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        init_end = 1'b1;
        tick();

        request(24'h40_0205, 10'd4, 16'hA000);
        wait_idle(100);

        request(24'($urandom), 10'd1, 16'($urandom));
        wait_idle(100);
        request(24'($urandom), 10'd0, 16'($urandom));
        wait_idle(100);
        request({2'($urandom), 13'($urandom), 9'h1F0}, 10'd512, 16'($urandom));
        wait_idle(700);

        for (int r = 0; r < 6; r++) begin
            request(24'($urandom), 10'($urandom_range(1, 40)), 16'($urandom));
            wait_idle(200);
        end

        init_end = 1'b0;
        rd_en = 1'b1;
        repeat (50) tick();
        rd_en = 1'b0;
        init_end = 1'b1;
        tick();

        request(24'($urandom), 10'd12, 16'($urandom));
        for (int t = 0; t < 30; t++) begin
            rd_en = 1'($urandom_range(0, 1));
            addr_in = 24'($urandom);
            len_in = 10'($urandom_range(1, 8));
            req_base = 16'($urandom);
            tick();
        end
        rd_en = 1'b0;
        wait_idle(200);

        request(24'($urandom), 10'd8, 16'($urandom));
        for (int t = 0; t < 20 && (g - acc[0]) < 8; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        request(24'($urandom), 10'd6, 16'($urandom));
        wait_idle(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
